// File: rtl/matrix_pkg.sv
// matrix_pkg: widths, FSM states and default timing shared by the dot-matrix
// scanner and its serial row driver.
package matrix_pkg;

   localparam int ROW_W = 16;
   localparam int COL_W = 4;

   localparam int DEF_CLK_DIV   = 2;
   localparam int DEF_BLANK_CYC = 4;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      SHIFT,
      LATCH
   } state_t;

endpackage

// File: rtl/matrix_shift_driver_if.sv
// matrix_shift_driver_if: column request in, 74HC595-style panel drive out.
interface matrix_shift_driver_if;
   import matrix_pkg::*;

   logic             load;
   logic [ROW_W-1:0] row_data;
   logic [COL_W-1:0] col_sel;
   logic             ser_data;
   logic             ser_clk;
   logic             ser_latch;
   logic             oe_n;
   logic [COL_W-1:0] col_out;
   logic             busy;
   logic             overrun;

   modport master (
      output load, row_data, col_sel,
      input  ser_data, ser_clk, ser_latch, oe_n, col_out, busy, overrun
   );

   modport slave (
      input  load, row_data, col_sel,
      output ser_data, ser_clk, ser_latch, oe_n, col_out, busy, overrun
   );

endinterface

// File: rtl/piso_shift16.sv
// piso_shift16: parallel-load, MSB-first shift register feeding the panel's
// serial data line; it also serves as the row shadow register.
module piso_shift16
   import matrix_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [ROW_W-1:0] i_data,
   output logic             o_msb
);

   logic [ROW_W-1:0] r_sr;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_sr <= '0;
      else if (i_load)
         r_sr <= i_data;
      else if (i_shift)
         r_sr <= {r_sr[ROW_W-2:0], 1'b0};
   end

   assign o_msb = r_sr[ROW_W-1];

endmodule

// File: rtl/matrix_shift_driver.sv
// matrix_shift_driver: blanks the panel, shifts one column's rows out serially,
// latches them, then switches the column select and re-enables the display.
module matrix_shift_driver
   import matrix_pkg::*;
#(
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int BLANK_CYC = DEF_BLANK_CYC,
   parameter bit ROW_INV   = 1'b0
) (
   input logic                  clk,
   input logic                  rst_n,
   matrix_shift_driver_if.slave bus
);

   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int BLK_W = $clog2(BLANK_CYC + 1);
   localparam logic [DIV_W-1:0] DIV_END = DIV_W'(CLK_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_END = BLK_W'(BLANK_CYC - 1);

   state_t           r_state;
   logic [DIV_W-1:0] r_div;
   logic [BLK_W-1:0] r_blank;
   logic [3:0]       r_bit;
   logic [COL_W-1:0] r_col;
   logic [COL_W-1:0] r_col_out;
   logic             r_ser_clk;
   logic             r_ser_latch;
   logic             r_oe_n;
   logic             r_busy;
   logic             r_overrun;
   logic             w_div_end;
   logic             w_load;
   logic             w_shift;
   logic             w_msb;
   logic [ROW_W-1:0] w_row;

   assign w_div_end = r_div == DIV_END;
   assign w_load    = r_state == IDLE && bus.load;
   // Advance to the next bit only at the end of a high phase; bit 0 is never shifted past.
   assign w_shift   = r_state == SHIFT && w_div_end && r_ser_clk && r_bit != 4'd0;
   assign w_row     = bus.row_data ^ {ROW_W{ROW_INV}};

   piso_shift16 u_piso (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (w_row),
      .o_msb   (w_msb)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_div       <= '0;
         r_blank     <= '0;
         r_bit       <= 4'd0;
         r_col       <= '0;
         r_col_out   <= '0;
         r_ser_clk   <= 1'b0;
         r_ser_latch <= 1'b0;
         r_oe_n      <= 1'b1;
         r_busy      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_overrun <= bus.load && r_state != IDLE;
         case (r_state)
            IDLE: if (bus.load) begin
               r_state <= BLANK;
               r_col   <= bus.col_sel;
               r_blank <= '0;
               r_busy  <= 1'b1;
               r_oe_n  <= 1'b1;
            end
            BLANK: if (r_blank == BLK_END) begin
               r_state <= SHIFT;
               r_div   <= '0;
               r_bit   <= 4'd15;
            end else begin
               r_blank <= r_blank + 1'b1;
            end
            SHIFT: if (!w_div_end) begin
               r_div <= r_div + 1'b1;
            end else begin
               r_div     <= '0;
               r_ser_clk <= !r_ser_clk;
               if (r_ser_clk && r_bit == 4'd0) begin
                  r_state     <= LATCH;
                  r_ser_latch <= 1'b1;
               end else if (r_ser_clk) begin
                  r_bit <= r_bit - 1'b1;
               end
            end
            LATCH: if (!w_div_end) begin
               r_div <= r_div + 1'b1;
            end else begin
               r_div       <= '0;
               r_state     <= IDLE;
               r_ser_latch <= 1'b0;
               r_col_out   <= r_col;
               r_oe_n      <= 1'b0;
               r_busy      <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.ser_data  = w_msb;
   assign bus.ser_clk   = r_ser_clk;
   assign bus.ser_latch = r_ser_latch;
   assign bus.oe_n      = r_oe_n;
   assign bus.col_out   = r_col_out;
   assign bus.busy      = r_busy;
   assign bus.overrun   = r_overrun;

endmodule

// File: doc/matrix_shift_driver.md
Name: matrix_shift_driver

Overview:
Downstream stage of the 16x16 dot-matrix column scanner. It accepts one column's 16-bit row pattern and 4-bit column index and shifts the pattern MSB-first into the panel's serial row drivers (74HC595-style data/clock/latch). It blanks the panel during the shift, then latches the new row data, updates the column select and re-enables the display. This keeps the matrix ghost-free, which a directly wired parallel row bus does not.

Parameters:
CLK_DIV, 2, clk cycles per ser_clk half-period; legal values are 1 or more.
BLANK_CYC, 4, clk cycles that oe_n is held high before shifting starts; legal values are 1 or more.
ROW_INV, 0, when 1 every shifted row bit is inverted (active-low LED rows).

Ports:
clk  input  1  single system clock; all logic is on the rising edge.
rst_n  input  1  synchronous active-low reset.
load  input  1  request to display the current row_data/col_sel; sampled on the rising edge.
row_data  input  16  row pattern for the column; bit 15 is shifted first.
col_sel  input  4  column index (0..15) belonging to row_data.
ser_data  output  1  serial row data to the panel.
ser_clk  output  1  serial shift clock to the panel; the panel samples on its rising edge.
ser_latch  output  1  storage-register latch pulse to the panel.
oe_n  output  1  active-low panel output enable.
col_out  output  4  registered column select driven to the column decoder.
busy  output  1  high while a transfer is in progress.
overrun  output  1  one-cycle pulse when a load is dropped.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values, applied on the first rising edge with rst_n=0:
  - state = IDLE
  - ser_data=0, ser_clk=0, ser_latch=0
  - oe_n=1, col_out=0
  - busy=0, overrun=0
  - shadow registers = 0
- Reset mid-transfer aborts the transfer immediately, with no partial latch.
- All outputs are registered.
- FSM states: IDLE, BLANK, SHIFT, LATCH.
- IDLE:
  - busy=0; oe_n keeps its previous value (0 after any completed transfer).
  - load=1 captures row_data (XORed with ROW_INV) and col_sel into shadow registers.
  - On the next edge: go to BLANK, busy=1, oe_n=1.
- BLANK:
  - oe_n=1 and ser_clk=0 for exactly BLANK_CYC cycles, then go to SHIFT.
- SHIFT:
  - 16 bits are sent, bit 15 first; each bit lasts 2*CLK_DIV cycles.
  - First CLK_DIV cycles: ser_clk=0, with ser_data driven to the bit at the start of the low phase.
  - Next CLK_DIV cycles: ser_clk=1, with ser_data held stable.
  - After bit 0's high phase: go to LATCH with ser_clk=0.
- LATCH:
  - ser_latch=1 for CLK_DIV cycles.
  - On exit: ser_latch=0, col_out=shadow column, oe_n=0, busy=0; go to IDLE.
- Total busy duration is BLANK_CYC + 32*CLK_DIV + CLK_DIV cycles (70 with the defaults).
- load while busy=1: the request is dropped, shadow registers are unchanged, and overrun pulses high for one cycle.
- A load on the cycle after the return to IDLE is accepted normally; there is no dead cycle beyond the IDLE cycle itself.
- load held continuously high: a new transfer starts on each IDLE cycle, and overrun pulses on every busy cycle.
- Changes to row_data or col_sel during busy have no effect.
- Counters:
  - The divide counter is ceil(log2(CLK_DIV+1)) bits and wraps to 0 at each phase end.
  - The bit counter is 4 bits and counts 15 down to 0.
  - The blank counter is sized for BLANK_CYC.
  - There is no wrap-around beyond these terminal counts.

Decomposition:
- Shared package matrix_pkg holds:
  - ROW_W=16, COL_W=4
  - the FSM state enum (IDLE, BLANK, SHIFT, LATCH)
  - the default CLK_DIV/BLANK_CYC constants, shared with the scanner's scan-rate generator
- One natural sub-module: piso_shift16. It is a 16-bit parallel-load, MSB-first shift register with load/shift enables, and it provides the current MSB to ser_data.
- The FSM and counters stay in matrix_shift_driver.

Test Plan:
1. Reset, then a single transfer. Stimulus: hold rst_n=0 for 3 cycles, then load=1 for one cycle with row_data=16'hA5C3, col_sel=4'd7. Required response:
   - busy is high for 70 cycles.
   - Sampling ser_data at the 16 ser_clk rising edges yields 1010_0101_1100_0011.
   - ser_latch is high for 2 cycles.
   - After that, col_out=7, oe_n=0, busy=0.
2. Blanking order. Stimulus: the same transfer as scenario 1. Required response: oe_n is high from the cycle after load until the cycle after ser_latch falls, and it is never low while ser_clk toggles.
3. Overrun. Stimulus: load at cycle 0, then load again at cycle 10 with row_data=16'hFFFF. Required response:
   - overrun pulses for 1 cycle at cycle 11.
   - The shifted pattern is still the first transfer's data.
   - No second transfer occurs.
4. Back-to-back transfers. Stimulus: after the first transfer completes, load on the first IDLE cycle with 16'h0001, col_sel=15. Required response: 15 zeros then a 1 are shifted, col_out=15, and there is no overrun.
5. ROW_INV=1 and CLK_DIV=1. Stimulus: load 16'h00FF. Required response:
   - Shifted bits are 1111_1111_0000_0000.
   - ser_clk half-period is 1 cycle.
   - busy lasts 4+32+1=37 cycles.
6. Mid-shift reset. Stimulus: assert rst_n=0 at bit 8 of a transfer. Required response:
   - On the next edge, all outputs take reset values: oe_n=1, ser_latch never pulsed, col_out=0.
   - After rst_n is released, a new load transfers correctly.
